sobel_rgb_filter: RTL and testbench

- Streaming 3x3 Sobel edge detector applied independently to the R, G and B channels of a raster-order pixel stream.
- Accepts one 24-bit RGB pixel per transfer and emits one 8-bit gradient magnitude per channel for each accepted pixel.
- Sits between a pixel source and three per-channel sinks; all interfaces use the valid/busy point-to-point protocol.

---
 rtl/sobel_rgb_filter.sv | 162 ++++++++++++++++
 tb/tb_sobel_rgb_filter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_rgb_filter.sv
// -----------------------------------------------------------------------------
// sobel_rgb_filter
//   Streaming 3x3 Sobel edge detector applied independently to the R, G and B
//   channels of a raster-order pixel stream. The window is causal: the pixel
//   just accepted is the bottom-right tap, and taps above row 0 or left of
//   column 0 read as zero. Each accepted pixel produces one registered result
//   per channel one edge later. The three channels drain independently.
//
// Ports
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_rgb_vld/busy/data   input pixel stream ([7:0]=R, [15:8]=G, [23:16]=B)
//   o_result_<c>_vld      result valid for channel c (r, g, b)
//   o_result_<c>_busy     sink for channel c cannot accept
//   o_result_<c>_data     8-bit saturated |Gx|+|Gy| for channel c
// -----------------------------------------------------------------------------
module sobel_rgb_filter #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rgb_vld,
  output logic        i_rgb_busy,
  input  logic [23:0] i_rgb_data,
  output logic        o_result_r_vld,
  input  logic        o_result_r_busy,
  output logic [7:0]  o_result_r_data,
  output logic        o_result_g_vld,
  input  logic        o_result_g_busy,
  output logic [7:0]  o_result_g_data,
  output logic        o_result_b_vld,
  input  logic        o_result_b_busy,
  output logic [7:0]  o_result_b_data
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  // One window column: the same image column taken from rows y-2, y-1 and y.
  typedef struct packed {
    logic [23:0] top;
    logic [23:0] mid;
    logic [23:0] bot;
  } column_t;

  // Row y-1 and row y-2 at every column.
  logic [23:0] lb_mid [WIDTH];
  logic [23:0] lb_top [WIDTH];

  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  column_t         prev1_q, prev1_d;   // column x-1
  column_t         prev2_q, prev2_d;   // column x-2
  logic [2:0]      vld_q, vld_d;       // {b, g, r}
  logic [2:0][7:0] data_q, data_d;

  logic [2:0]      sink_busy;
  logic            accept;
  column_t         col_c0, col_c1, col_c2;
  logic [2:0][7:0] result;

  function automatic logic [7:0] sobel(input column_t c0, input column_t c1,
                                       input column_t c2, input int unsigned ch);
    logic [7:0]         w00, w01, w02, w10, w12, w20, w21, w22;
    logic [11:0]        gx_p, gx_n, gy_p, gy_n, abs_gx, abs_gy, mag;
    logic signed [11:0] gx, gy;
    w00 = c0.top[ch*8 +: 8]; w01 = c1.top[ch*8 +: 8]; w02 = c2.top[ch*8 +: 8];
    w10 = c0.mid[ch*8 +: 8];                          w12 = c2.mid[ch*8 +: 8];
    w20 = c0.bot[ch*8 +: 8]; w21 = c1.bot[ch*8 +: 8]; w22 = c2.bot[ch*8 +: 8];
    // Positive and negative kernel halves are each at most 1020, so both fit
    // as non-negative values of a 12-bit signed difference.
    gx_p = {4'b0, w02} + {3'b0, w12, 1'b0} + {4'b0, w22};
    gx_n = {4'b0, w00} + {3'b0, w10, 1'b0} + {4'b0, w20};
    gy_p = {4'b0, w20} + {3'b0, w21, 1'b0} + {4'b0, w22};
    gy_n = {4'b0, w00} + {3'b0, w01, 1'b0} + {4'b0, w02};
    gx = $signed(gx_p) - $signed(gx_n);
    gy = $signed(gy_p) - $signed(gy_n);
    abs_gx = gx[11] ? 12'(-gx) : 12'(gx);
    abs_gy = gy[11] ? 12'(-gy) : 12'(gy);
    mag = abs_gx + abs_gy;
    return (mag > 12'd255) ? 8'hFF : mag[7:0];
  endfunction

  assign sink_busy = {o_result_b_busy, o_result_g_busy, o_result_r_busy};

  // Stall only when some channel is still pending and its sink is busy; a
  // channel draining this cycle frees its part of the slot for a new load.
  assign i_rgb_busy = |(vld_q & sink_busy);
  assign accept     = i_rgb_vld & ~i_rgb_busy;

  // Window assembly; zero padding comes from the position counters so the
  // line buffers never need clearing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    col_c2     = '0;
    col_c2.bot = i_rgb_data;
    col_c2.mid = (y_q != '0)      ? lb_mid[x_q] : '0;
    col_c2.top = (y_q > YW'(1))   ? lb_top[x_q] : '0;
    col_c1     = (x_q != '0)      ? prev1_q     : '0;
    col_c0     = (x_q > XW'(1))   ? prev2_q     : '0;
    for (int ch = 0; ch < 3; ch++) begin
      result[ch] = sobel(col_c0, col_c1, col_c2, ch);
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    vld_d   = vld_q & sink_busy;   // taken channels drop their own vld
    data_d  = data_q;
    if (accept) begin
      vld_d   = 3'b111;
      data_d  = result;
      prev2_d = prev1_q;
      prev1_d = col_c2;
      if (x_q == XW'(WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (i_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      prev1_q <= '0;
      prev2_q <= '0;
      vld_q   <= '0;
      data_q  <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  // NOTE: the line buffers are deliberately not reset; stale contents are
  // masked by the row counter, which keeps them mappable to plain RAM.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb_top[x_q] <= lb_mid[x_q];
      lb_mid[x_q] <= i_rgb_data;
    end
  end

  assign o_result_r_vld  = vld_q[0];
  assign o_result_g_vld  = vld_q[1];
  assign o_result_b_vld  = vld_q[2];
  assign o_result_r_data = data_q[0];
  assign o_result_g_data = data_q[1];
  assign o_result_b_data = data_q[2];

endmodule

// File: tb/tb_sobel_rgb_filter.sv
// -----------------------------------------------------------------------------
// tb_sobel_rgb_filter
//   Directed bench for sobel_rgb_filter. A full-size instance (512x512) covers
//   the constant, edge, impulse, backpressure and reset scenarios; a 4x2
//   instance covers frame wrap. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_sobel_rgb_filter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Full-size instance
  logic        rst = 1'b1, vld = 1'b0, busy;
  logic [23:0] data = '0;
  logic        r_vld, g_vld, b_vld;
  logic        r_busy = 1'b0, g_busy = 1'b0, b_busy = 1'b0;
  logic [7:0]  r_data, g_data, b_data;

  // Small instance for frame wrap
  logic        w_rst = 1'b1, w_vld = 1'b0, w_busy;
  logic [23:0] w_data = '0;
  logic        w_r_vld, w_g_vld, w_b_vld;
  logic [7:0]  w_r_data, w_g_data, w_b_data;

  sobel_rgb_filter dut (
    .i_clk(clk), .i_rst(rst),
    .i_rgb_vld(vld), .i_rgb_busy(busy), .i_rgb_data(data),
    .o_result_r_vld(r_vld), .o_result_r_busy(r_busy), .o_result_r_data(r_data),
    .o_result_g_vld(g_vld), .o_result_g_busy(g_busy), .o_result_g_data(g_data),
    .o_result_b_vld(b_vld), .o_result_b_busy(b_busy), .o_result_b_data(b_data)
  );

  sobel_rgb_filter #(.WIDTH(4), .HEIGHT(2)) dut_small (
    .i_clk(clk), .i_rst(w_rst),
    .i_rgb_vld(w_vld), .i_rgb_busy(w_busy), .i_rgb_data(w_data),
    .o_result_r_vld(w_r_vld), .o_result_r_busy(1'b0), .o_result_r_data(w_r_data),
    .o_result_g_vld(w_g_vld), .o_result_g_busy(1'b0), .o_result_g_data(w_g_data),
    .o_result_b_vld(w_b_vld), .o_result_b_busy(1'b0), .o_result_b_data(w_b_data)
  );

  // Present one pixel and hold it until accepted; outputs are then sampled 1ns
  // after the accepting edge.
  task automatic push(input logic [23:0] d);
    int n = 0;
    vld = 1'b1; data = d;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n == 100) begin
      tests++; fails++;
      $display("FAIL push_timeout: busy stuck at %0b, required 0", busy);
    end
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic push_w(input logic [23:0] d);
    int n = 0;
    w_vld = 1'b1; w_data = d;
    while (w_busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n == 100) begin
      tests++; fails++;
      $display("FAIL push_w_timeout: busy stuck at %0b, required 0", w_busy);
    end
    @(posedge clk); #1;
    w_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    r_busy = 0; g_busy = 0; b_busy = 0;
    do_reset();
    tests++;
    if ({r_vld, g_vld, b_vld, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_vld_busy: got %b, required 0000", {r_vld, g_vld, b_vld, busy});
    end
    tests++;
    if ({r_data, g_data, b_data} !== 24'h0) begin
      fails++;
      $display("FAIL reset_data: got %h, required 000000", {r_data, g_data, b_data});
    end
  endtask

  task automatic test_constant();
    time t0;
    do_reset();
    t0 = $time;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 512; x++) begin
        push(24'h646464);
        tests++;
        if ({r_vld, g_vld, b_vld} !== 3'b111) begin
          fails++;
          $display("FAIL const_vld (%0d,%0d): got %b, required 111", y, x, {r_vld, g_vld, b_vld});
        end
        if ((y == 0 && x <= 1) || (y == 2 && x >= 2)) begin
          logic [7:0] e;
          e = (y == 0 && x == 0) ? 8'd200 : (y == 0) ? 8'd255 : 8'd0;
          tests++;
          if ({r_data, g_data, b_data} !== {e, e, e}) begin
            fails++;
            $display("FAIL const_data (%0d,%0d): got %h, required %h", y, x,
                     {r_data, g_data, b_data}, {e, e, e});
          end
        end
      end
    end
    tests++;
    if (($time - t0) / 10 != 1536) begin
      fails++;
      $display("FAIL const_throughput: got %0d cycles, required 1536", ($time - t0) / 10);
    end
    @(posedge clk); #1;
    tests++;
    if ({r_vld, g_vld, b_vld} !== 3'b000) begin
      fails++;
      $display("FAIL const_drain: got %b, required 000", {r_vld, g_vld, b_vld});
    end
  endtask

  task automatic test_vertical_edge();
    do_reset();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 512; x++) begin
        push((x >= 256) ? 24'h000050 : 24'h0);
        if (y == 2 && x >= 2) begin
          logic [7:0] e;
          e = (x == 256 || x == 257) ? 8'd255 : 8'd0;
          tests++;
          if ({r_data, g_data, b_data} !== {e, 16'h0}) begin
            fails++;
            $display("FAIL vedge (%0d,%0d): got %h, required %h", y, x,
                     {r_data, g_data, b_data}, {e, 16'h0});
          end
        end
      end
    end
  endtask

  task automatic test_impulse();
    do_reset();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 512; x++) begin
        push((y == 0 && x == 0) ? 24'h0000FF : 24'h0);
        if ((y == 0 && x <= 1) || (y == 1 && x == 0)) begin
          tests++;
          if ({r_data, g_data, b_data} !== 24'hFF0000) begin
            fails++;
            $display("FAIL impulse_near (%0d,%0d): got %h, required ff0000", y, x,
                     {r_data, g_data, b_data});
          end
        end else if (y == 2 && x >= 3) begin
          tests++;
          if ({r_data, g_data, b_data} !== 24'h0) begin
            fails++;
            $display("FAIL impulse_far (%0d,%0d): got %h, required 000000", y, x,
                     {r_data, g_data, b_data});
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nr = 0, ng = 0, nb = 0;
    r_busy = 0; g_busy = 1; b_busy = 0;
    do_reset();
    push(24'h646464);
    tests++;
    if ({r_vld, g_vld, b_vld, r_data, g_data, b_data} !== {3'b111, 8'd200, 8'd200, 8'd200}) begin
      fails++;
      $display("FAIL bp_load: got %b/%h, required 111/c8c8c8", {r_vld, g_vld, b_vld},
               {r_data, g_data, b_data});
    end
    vld = 1'b1; data = 24'h646464;
    for (int i = 0; i < 5; i++) begin
      if (r_vld && !r_busy) nr++;
      if (g_vld && !g_busy) ng++;
      if (b_vld && !b_busy) nb++;
      @(posedge clk); #1;
      tests++;
      if ({r_vld, g_vld, b_vld, busy, g_data} !== {4'b0101, 8'd200}) begin
        fails++;
        $display("FAIL bp_stall cycle %0d: got vld=%b busy=%b g=%0d, required vld=010 busy=1 g=200",
                 i, {r_vld, g_vld, b_vld}, busy, g_data);
      end
    end
    g_busy = 0;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_release_busy: got %b, required 0", busy);
    end
    if (r_vld && !r_busy) nr++;
    if (g_vld && !g_busy) ng++;
    if (b_vld && !b_busy) nb++;
    @(posedge clk); #1;
    vld = 1'b0;
    tests++;
    if ({r_vld, g_vld, b_vld, r_data, g_data, b_data} !== {3'b111, 24'hFFFFFF}) begin
      fails++;
      $display("FAIL bp_next_load: got %b/%h, required 111/ffffff", {r_vld, g_vld, b_vld},
               {r_data, g_data, b_data});
    end
    if (r_vld && !r_busy) nr++;
    if (g_vld && !g_busy) ng++;
    if (b_vld && !b_busy) nb++;
    @(posedge clk); #1;
    tests++;
    if ({r_vld, g_vld, b_vld} !== 3'b000 || nr != 2 || ng != 2 || nb != 2) begin
      fails++;
      $display("FAIL bp_counts: got vld=%b r=%0d g=%0d b=%0d, required vld=000 r=2 g=2 b=2",
               {r_vld, g_vld, b_vld}, nr, ng, nb);
    end
  endtask

  task automatic test_reset_mid_row();
    r_busy = 0; g_busy = 0; b_busy = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push(24'h646464);
    g_busy = 1;
    push(24'h646464);
    do_reset();
    tests++;
    if ({r_vld, g_vld, b_vld, busy, r_data, g_data, b_data} !== 28'h0) begin
      fails++;
      $display("FAIL midrst_clear: got vld=%b busy=%b data=%h, required all zero",
               {r_vld, g_vld, b_vld}, busy, {r_data, g_data, b_data});
    end
    g_busy = 0;
    push(24'h646464);
    tests++;
    if ({r_data, g_data, b_data} !== {8'd200, 8'd200, 8'd200}) begin
      fails++;
      $display("FAIL midrst_first: got %h, required c8c8c8", {r_data, g_data, b_data});
    end
    push(24'h646464);
    tests++;
    if ({r_data, g_data, b_data} !== 24'hFFFFFF) begin
      fails++;
      $display("FAIL midrst_second: got %h, required ffffff", {r_data, g_data, b_data});
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] e;
    w_rst = 1'b1;
    @(posedge clk); #1;
    w_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_w(24'h646464);
      if (i == 0 || i == 7 || i == 8 || i == 9) begin
        e = (i == 0 || i == 8) ? 8'd200 : 8'd255;
        tests++;
        if ({w_r_vld, w_g_vld, w_b_vld, w_r_data, w_g_data, w_b_data} !== {3'b111, e, e, e}) begin
          fails++;
          $display("FAIL wrap pixel %0d: got %b/%h, required 111/%h", i,
                   {w_r_vld, w_g_vld, w_b_vld}, {w_r_data, w_g_data, w_b_data}, {e, e, e});
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_constant();
    test_vertical_edge();
    test_impulse();
    test_backpressure();
    test_reset_mid_row();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
